// File: rtl/ifetch_pkg.sv
// Shared widths, entry type and PC arithmetic for the instruction fetch stage.
package ifetch_pkg;

  localparam int PC_W    = 16;
  localparam int INSTR_W = 16;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  localparam fetch_entry_t EMPTY_ENTRY = '{pc: '0, instr: NOP_INSTR};

  // Sequential PC advance; wraps modulo 2^PC_W.
  function automatic logic [PC_W-1:0] pc_advance(input logic [PC_W-1:0] pc,
                                                 input int unsigned   step);
    return pc + PC_W'(step);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO of {pc, instr} pairs between fetch and decode.
module fetch_queue
  import ifetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head_entry,
  output logic [1:0]   count
);

  fetch_entry_t entry_q [2];
  logic         head_q;
  logic         tail_q;
  logic [1:0]   count_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      entry_q[0] <= EMPTY_ENTRY;
      entry_q[1] <= EMPTY_ENTRY;
      head_q     <= 1'b0;
      tail_q     <= 1'b0;
      count_q    <= 2'd0;
    end else if (flush) begin
      // Entry contents are left alone; only the occupancy is discarded.
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      // At count 2 a push is only allowed alongside a pop, so the tail slot
      // being written is the head slot being released.
      if (push) begin
        entry_q[tail_q] <= push_entry;
        tail_q          <= ~tail_q;
      end
      if (pop) begin
        head_q <= ~head_q;
      end
      count_q <= count_q + 2'(push) - 2'(pop);
    end
  end

  assign head_entry = entry_q[head_q];
  assign count      = count_q;

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch-stage sequencer: owns the PC, drives the ROM address and feeds decode
// through a 2-entry queue, with redirect flush and a program-limit stall.
module instr_fetch_ctrl
  import ifetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 16'h0000,
  parameter int unsigned     PC_STEP  = 2,
  parameter logic [PC_W-1:0] PC_LIMIT = 16'd32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fetch_en,
  output logic [PC_W-1:0]    imem_pc,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  output logic               idle,
  output logic [15:0]        delivered_cnt
);

  logic [PC_W-1:0] pc_q;
  logic [15:0]     delivered_q;
  fetch_entry_t    hold_q;
  fetch_entry_t    head_entry;
  fetch_entry_t    push_entry;
  logic [1:0]      count;
  logic            queue_nonempty;
  logic            pc_in_range;
  logic            pop;
  logic            do_fetch;

  assign queue_nonempty = (count != 2'd0);
  assign pc_in_range    = (pc_q < PC_LIMIT);

  // A redirect cycle hides the head so no handshake can complete with it.
  assign out_valid = queue_nonempty & ~redirect_valid;
  assign pop       = out_valid & out_ready;
  assign do_fetch  = fetch_en & ~redirect_valid & pc_in_range
                   & ((count < 2'd2) | pop);

  assign push_entry = '{pc: pc_q, instr: imem_instr};

  fetch_queue u_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (do_fetch),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (redirect_valid),
    .head_entry (head_entry),
    .count      (count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      delivered_q <= 16'd0;
      hold_q      <= EMPTY_ENTRY;
    end else begin
      if (redirect_valid) begin
        pc_q <= redirect_pc;
      end else if (do_fetch) begin
        pc_q <= pc_advance(pc_q, PC_STEP);
      end
      if (pop) begin
        delivered_q <= delivered_q + 16'd1;
      end
      // Remembers the most recently presented head so the outputs keep
      // their last value once the queue runs empty.
      if (queue_nonempty) begin
        hold_q <= head_entry;
      end
    end
  end

  assign out_pc        = queue_nonempty ? head_entry.pc    : hold_q.pc;
  assign out_instr     = queue_nonempty ? head_entry.instr : hold_q.instr;
  assign imem_pc       = pc_q;
  assign idle          = ~queue_nonempty & ~(fetch_en & pc_in_range);
  assign delivered_cnt = delivered_q;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Self-checking bench for instr_fetch_ctrl: directed scenarios plus a random
// run against a queue-based reference model.
module tb_instr_fetch_ctrl;

  localparam logic [15:0] LIMIT = 16'd32;

  logic        clk;
  logic        rst_n;
  logic        fetch_en;
  logic [15:0] imem_pc;
  logic [15:0] imem_instr;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instr;
  logic [15:0] out_pc;
  logic        idle;
  logic [15:0] delivered_cnt;

  logic [15:0] rom_mem [64];
  assign imem_instr = rom_mem[imem_pc[6:1]];

  instr_fetch_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .imem_pc        (imem_pc),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .idle           (idle),
    .delivered_cnt  (delivered_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;

  // Reference model: program counter, a queue of {pc, instr}, last shown head.
  typedef struct {
    logic [15:0] pc;
    logic [15:0] instr;
  } ent_t;

  ent_t        mq[$];
  logic [15:0] m_pc;
  logic [15:0] m_last_pc;
  logic [15:0] m_last_instr;
  logic [15:0] m_dcnt;
  logic        e_valid;
  logic        e_idle;
  logic [15:0] e_pc;
  logic [15:0] e_instr;

  task automatic drive(input logic f, input logic r, input logic v,
                       input logic [15:0] p, input logic n);
    @(negedge clk);
    fetch_en       = f;
    out_ready      = r;
    redirect_valid = v;
    redirect_pc    = p;
    rst_n          = n;
    #1;
    e_valid = (mq.size() != 0) && !v;
    e_pc    = (mq.size() != 0) ? mq[0].pc    : m_last_pc;
    e_instr = (mq.size() != 0) ? mq[0].instr : m_last_instr;
    e_idle  = (mq.size() == 0) && !(f && (m_pc < LIMIT));
  endtask

  // Advances the model by the rules for the inputs now applied, then the clock.
  task automatic tick();
    logic pop_m;
    logic fetch_m;
    if (!rst_n) begin
      m_pc = 16'h0000;
      mq.delete();
      m_last_pc    = 16'h0000;
      m_last_instr = 16'h0000;
      m_dcnt       = 16'h0000;
    end else begin
      pop_m   = e_valid && out_ready;
      fetch_m = fetch_en && !redirect_valid && (m_pc < LIMIT)
              && ((mq.size() < 2) || pop_m);
      if (mq.size() != 0) begin
        m_last_pc    = mq[0].pc;
        m_last_instr = mq[0].instr;
      end
      if (redirect_valid) begin
        mq.delete();
        m_pc = redirect_pc;
      end else begin
        if (pop_m) begin
          void'(mq.pop_front());
          m_dcnt = m_dcnt + 16'd1;
        end
        if (fetch_m) begin
          mq.push_back('{m_pc, rom_mem[m_pc[6:1]]});
          m_pc = m_pc + 16'd2;
        end
      end
    end
    @(posedge clk);
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
    vectors++;
    if (out_valid !== 1'b0 || out_pc !== 16'h0000 || out_instr !== 16'h0000 ||
        delivered_cnt !== 16'h0000 || idle !== 1'b1 || imem_pc !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset: valid=%b pc=%h instr=%h dcnt=%0d idle=%b imem_pc=%h, want 0 0 0 0 1 0",
               out_valid, out_pc, out_instr, delivered_cnt, idle, imem_pc);
    end
    tick();
  endtask

  task automatic test_free_run();
    logic        ev;
    logic [15:0] ep;
    do_reset();
    for (int c = 0; c < 20; c++) begin
      drive(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1);
      ev = (c >= 1 && c <= 16);
      ep = 16'(2 * (c - 1));
      vectors++;
      if (out_valid !== ev || (ev && (out_pc !== ep || out_instr !== (16'hA000 | ep)))) begin
        miscompares++;
        $display("FAIL free_run c=%0d: valid=%b pc=%h instr=%h, want valid=%b pc=%h instr=%h",
                 c, out_valid, out_pc, out_instr, ev, ep, 16'hA000 | ep);
      end
      tick();
    end
    drive(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1);
    vectors++;
    if (idle !== 1'b1 || delivered_cnt !== 16'd16 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL free_run_end: idle=%b dcnt=%0d valid=%b, want 1 16 0",
               idle, delivered_cnt, out_valid);
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic [15:0] got[$];
    do_reset();
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1);
      vectors++;
      if (c >= 1 && (out_valid !== 1'b1 || out_pc !== 16'h0000)) begin
        miscompares++;
        $display("FAIL backpressure_hold c=%0d: valid=%b pc=%h, want 1 0000", c, out_valid, out_pc);
      end
      tick();
    end
    drive(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1);
    vectors++;
    if (imem_pc !== 16'h0004 || delivered_cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL backpressure_pc: imem_pc=%h dcnt=%0d, want 0004 0", imem_pc, delivered_cnt);
    end
    tick();
    for (int c = 0; c < 6; c++) begin
      drive(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1);
      if (out_valid === 1'b1) got.push_back(out_pc);
      tick();
    end
    vectors++;
    if (got.size() < 3 || got[0] !== 16'h0000 || got[1] !== 16'h0002 || got[2] !== 16'h0004) begin
      miscompares++;
      $display("FAIL backpressure_order: got %0d entries first=%h,%h,%h, want 0000,0002,0004",
               got.size(), got.size() > 0 ? got[0] : 16'hxxxx,
               got.size() > 1 ? got[1] : 16'hxxxx, got.size() > 2 ? got[2] : 16'hxxxx);
    end
    for (int i = 1; i < got.size(); i++) begin
      vectors++;
      if (got[i] !== got[i-1] + 16'd2) begin
        miscompares++;
        $display("FAIL backpressure_seq i=%0d: pc=%h, want %h", i, got[i], got[i-1] + 16'd2);
      end
    end
  endtask

  task automatic test_redirect();
    logic [15:0] got[$];
    do_reset();
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1);
      tick();
    end
    drive(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1);
    tick();
    drive(1'b1, 1'b1, 1'b1, 16'h0010, 1'b1);
    vectors++;
    if (out_valid !== 1'b0 || delivered_cnt !== 16'd2 || out_pc !== 16'h0004) begin
      miscompares++;
      $display("FAIL redirect_cycle: valid=%b dcnt=%0d head=%h, want 0 2 0004",
               out_valid, delivered_cnt, out_pc);
    end
    tick();
    drive(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1);
    vectors++;
    if (delivered_cnt !== 16'd2 || out_valid !== 1'b0 || imem_pc !== 16'h0010) begin
      miscompares++;
      $display("FAIL redirect_after: dcnt=%0d valid=%b imem_pc=%h, want 2 0 0010",
               delivered_cnt, out_valid, imem_pc);
    end
    tick();
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1);
      if (out_valid === 1'b1) got.push_back(out_pc);
      tick();
    end
    vectors++;
    if (got.size() < 2 || got[0] !== 16'h0010 || got[1] !== 16'h0012) begin
      miscompares++;
      $display("FAIL redirect_target: got %0d entries first=%h,%h, want 0010,0012", got.size(),
               got.size() > 0 ? got[0] : 16'hxxxx, got.size() > 1 ? got[1] : 16'hxxxx);
    end
  endtask

  task automatic test_redirect_limit();
    logic [15:0] got[$];
    drive(1'b1, 1'b1, 1'b1, 16'h0040, 1'b1);
    tick();
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1);
      vectors++;
      if (out_valid !== 1'b0 || idle !== 1'b1 || imem_pc !== 16'h0040) begin
        miscompares++;
        $display("FAIL redirect_limit c=%0d: valid=%b idle=%b imem_pc=%h, want 0 1 0040",
                 c, out_valid, idle, imem_pc);
      end
      tick();
    end
    drive(1'b1, 1'b1, 1'b1, 16'h0000, 1'b1);
    tick();
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1);
      if (out_valid === 1'b1) got.push_back(out_pc);
      tick();
    end
    vectors++;
    if (got.size() < 1 || got[0] !== 16'h0000) begin
      miscompares++;
      $display("FAIL redirect_resume: got %0d entries first=%h, want 0000", got.size(),
               got.size() > 0 ? got[0] : 16'hxxxx);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] got[$];
    int          drained;
    do_reset();
    for (int c = 0; c < 2; c++) begin
      drive(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1);
      tick();
    end
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1);
      vectors++;
      if (out_valid !== 1'b1 || imem_pc !== 16'(4 + 2 * c)) begin
        miscompares++;
        $display("FAIL full_stream c=%0d: valid=%b imem_pc=%h, want 1 %h",
                 c, out_valid, imem_pc, 16'(4 + 2 * c));
      end
      got.push_back(out_pc);
      tick();
    end
    drained = 0;
    for (int c = 0; c < 5; c++) begin
      drive(1'b0, 1'b1, 1'b0, 16'h0000, 1'b1);
      if (out_valid === 1'b1) begin
        drained++;
        got.push_back(out_pc);
      end
      vectors++;
      if (imem_pc !== 16'h000C) begin
        miscompares++;
        $display("FAIL fetch_off_pc c=%0d: imem_pc=%h, want 000c", c, imem_pc);
      end
      tick();
    end
    vectors++;
    if (drained != 2) begin
      miscompares++;
      $display("FAIL fetch_off_drain: delivered %0d, want 2", drained);
    end
    for (int i = 0; i < got.size(); i++) begin
      vectors++;
      if (got[i] !== 16'(2 * i)) begin
        miscompares++;
        $display("FAIL full_stream_seq i=%0d: pc=%h, want %h", i, got[i], 16'(2 * i));
      end
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1);
      tick();
    end
    for (int c = 0; c < 2; c++) begin
      drive(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1);
      tick();
    end
    drive(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
    vectors++;
    if (delivered_cnt !== 16'd3 || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_reset_pre: dcnt=%0d valid=%b, want 3 1", delivered_cnt, out_valid);
    end
    tick();
    drive(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1);
    vectors++;
    if (out_valid !== 1'b0 || imem_pc !== 16'h0000 || delivered_cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL mid_reset_post: valid=%b imem_pc=%h dcnt=%0d, want 0 0000 0",
               out_valid, imem_pc, delivered_cnt);
    end
    tick();
    drive(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1);
    vectors++;
    if (out_valid !== 1'b1 || out_pc !== 16'h0000) begin
      miscompares++;
      $display("FAIL mid_reset_first: valid=%b pc=%h, want 1 0000", out_valid, out_pc);
    end
    tick();
  endtask

  task automatic test_random();
    logic        f;
    logic        r;
    logic        v;
    logic        n;
    logic [15:0] p;
    for (int i = 0; i < 64; i++) rom_mem[i] = 16'($urandom);
    do_reset();
    for (int c = 0; c < 600; c++) begin
      f = ($urandom_range(0, 9) < 8);
      r = ($urandom_range(0, 9) < 7);
      v = ($urandom_range(0, 99) < 8);
      n = ($urandom_range(0, 99) != 0);
      p = ($urandom_range(0, 5) == 0) ? 16'(16'h0020 + 2 * $urandom_range(0, 100))
                                      : 16'(2 * $urandom_range(0, 15));
      drive(f, r, v, p, n);
      vectors++;
      if (out_valid !== e_valid || idle !== e_idle || imem_pc !== m_pc ||
          delivered_cnt !== m_dcnt || out_pc !== e_pc || out_instr !== e_instr) begin
        miscompares++;
        $display("FAIL random c=%0d: valid=%b idle=%b imem_pc=%h dcnt=%0d pc=%h instr=%h, want %b %b %h %0d %h %h",
                 c, out_valid, idle, imem_pc, delivered_cnt, out_pc, out_instr,
                 e_valid, e_idle, m_pc, m_dcnt, e_pc, e_instr);
      end
      tick();
    end
  endtask

  initial begin
    vectors        = 0;
    miscompares    = 0;
    rst_n          = 1'b0;
    fetch_en       = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 16'h0000;
    m_pc           = 16'h0000;
    m_last_pc      = 16'h0000;
    m_last_instr   = 16'h0000;
    m_dcnt         = 16'h0000;
    for (int i = 0; i < 64; i++) rom_mem[i] = 16'hA000 | 16'(2 * i);

    test_reset();
    test_free_run();
    test_backpressure();
    test_redirect();
    test_redirect_limit();
    test_back_to_back();
    test_mid_reset();
    test_random();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instr_fetch_ctrl.md
Name: instr_fetch_ctrl

Overview:
- Fetch-stage sequencer for the combinational instruction ROM.
- Owns the program counter and drives the ROM address every cycle.
- Captures {pc, instruction} pairs into a 2-entry fetch queue and hands them to decode over a valid/ready handshake.
- Applies redirects from branch/jump resolution (JLR, BEQ, JAL) with a same-cycle flush, and stops fetching at a configurable program limit.

Parameters:
- PC_W, 16, program counter and ROM address width.
- INSTR_W, 16, instruction width.
- RESET_PC, 16'h0000, PC loaded on reset.
- PC_STEP, 2, byte increment per sequential fetch; ROM is word-indexed by pc[6:1].
- PC_LIMIT, 32, first byte address not fetched; fetch stalls when pc_q >= PC_LIMIT.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- fetch_en  in  1  enables new fetches; drain continues while low
- imem_pc  out  PC_W  ROM address; equals pc_q
- imem_instr  in  INSTR_W  ROM data, combinational from imem_pc in the same cycle
- redirect_valid  in  1  branch/jump resolved; load redirect_pc
- redirect_pc  in  PC_W  redirect target
- out_valid  out  1  head entry valid for decode
- out_ready  in  1  decode accepts head entry
- out_instr  out  INSTR_W  head instruction
- out_pc  out  PC_W  head instruction address
- idle  out  1  queue empty and no fetch possible
- delivered_cnt  out  16  count of completed out handshakes

Behaviour:
- Reset (sampled on a clk edge with rst_n=0) produces:
  - pc_q=RESET_PC, queue count=0, head/tail pointers 0.
  - out_valid=0, out_instr=0, out_pc=0.
  - delivered_cnt=0, idle=1 (combinational from state).
- Reset has priority over every other input. Asserting reset mid-operation discards queued entries and any pending redirect.
- Fetch condition: do_fetch = fetch_en & ~redirect_valid & (pc_q < PC_LIMIT) & (count<2 | pop).
- On do_fetch:
  - Push {pc_q, imem_instr} at the tail.
  - pc_q <= pc_q + PC_STEP, modulo 2^PC_W. Wrap at 16'hFFFE+2 is to 0, though PC_LIMIT normally prevents this.
- Pop: pop = out_valid & out_ready. It advances the head and increments delivered_cnt, which wraps at 2^16.
- out_valid = (count!=0) & ~redirect_valid, gated combinationally. No handshake completes in a redirect cycle.
- out_instr/out_pc present the head entry registers and hold stable while out_valid=1 and out_ready=0.
- Latency: an instruction fetched in cycle N is presented at the head in cycle N+1 if the queue was empty. The first instruction after reset release appears with out_valid=1 one cycle after the first fetch.
- Full (count==2):
  - No push unless pop in the same cycle.
  - Simultaneous push+pop at count 2 keeps count=2; at count 1 it keeps count=1.
- Empty: out_valid=0, out_instr/out_pc hold their last values.
- Redirect (redirect_valid=1), applied at the next edge:
  - Flush the queue (count=0).
  - pc_q <= redirect_pc.
  - No push, no pop.
  - A redirect_pc >= PC_LIMIT leaves fetch stalled.
- Back-to-back redirects: the last one wins. Each flushes the queue.
- fetch_en=0: no pushes. Queued entries still drain. pc_q holds.
- idle = (count==0) & ~(fetch_en & pc_q<PC_LIMIT).
- Queue internals:
  - Two entry registers plus 1-bit head/tail pointers and a 2-bit count.
  - Pointers wrap 1->0.

Decomposition:
- Shared package ifetch_pkg holds:
  - PC_W, INSTR_W.
  - NOP_INSTR = 16'h0000.
  - Typedef fetch_entry_t {pc, instr}.
- Sub-module fetch_queue: 2-entry FIFO of fetch_entry_t with push, pop, flush, count, head outputs. Flush has priority over push/pop.
- instr_fetch_ctrl holds PC logic, fetch condition, counter.

Test Plan:
- Free-run: reset, fetch_en=1, out_ready=1, ROM model returns 16'hA000|pc.
  - out_pc sequence 0,2,4,...,30 on consecutive cycles starting cycle 1.
  - Then out_valid=0, idle=1, delivered_cnt=16.
- Backpressure: out_ready=0 for 5 cycles after reset.
  - Queue holds pc 0,2; pc_q=4; out_pc=0 stable.
  - Release ready: 0,2,4 delivered in order with no duplicates or gaps.
- Redirect: with count=2 (pc 4,6 queued), assert redirect_valid, redirect_pc=16'h0010 for one cycle.
  - out_valid=0 that cycle, delivered_cnt unchanged.
  - Next delivered out_pc=16'h0010, then 16'h0012.
- Redirect past limit: redirect_pc=16'h0040.
  - No further out_valid; idle=1 next cycle.
  - A later redirect_pc=0 resumes at 0.
- Simultaneous push/pop at full with fetch_en toggled low mid-stream.
  - Count stays 2 while fetching.
  - After fetch_en=0, exactly 2 more entries are delivered and pc_q holds.
- Mid-operation reset: rst_n=0 for 1 cycle with 2 entries queued.
  - Next cycle out_valid=0, pc_q=0, delivered_cnt=0.
  - Then out_pc=0 is delivered.
